// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs bytes little-endian into
// words, writes them at incrementing addresses and holds the CPU in reset until done.
module imem_loader #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   word_count,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_rst,
    output logic [7:0]               checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH:0]   count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]               idx_q, idx_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [7:0]               checksum_q, checksum_d;
    logic [ADDRESS_WIDTH:0]   clamped_count;

    assign clamped_count = (word_count > DEPTH) ? DEPTH : word_count;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        word_d     = word_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        checksum_d = checksum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d    = clamped_count;
                    addr_d     = '0;
                    idx_d      = '0;
                    checksum_d = '0;
                    state_d    = (clamped_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    word_d[{idx_q, 3'b000} +: 8] = byte_data;
                    checksum_d = checksum_q + byte_data;
                    idx_d      = idx_q + 2'd1;
                    // The write registers are loaded here so they present the word in WRITE
                    // and then hold it untouched while the next word is gathered.
                    if (idx_q == 2'd3) begin
                        state_d   = S_WRITE;
                        wr_addr_d = addr_q;
                        wr_data_d = word_d;
                    end
                end
            end
            default: begin
                if (({1'b0, addr_q} + 1'b1) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            checksum_q <= checksum_d;
        end
    end

    assign byte_ready = (state_q == S_LOAD);
    assign wr_en      = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign cpu_rst    = (state_q != S_DONE);
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a cycle model of the loader's observable rules plus
// a memory-image check built from the bytes the bench saw accepted.
module tb_imem_loader;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, wr_en, busy, done, cpu_rst;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [7:0]    checksum;

    int n_checks = 0;
    int n_errors = 0;

    imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .cpu_rst(cpu_rst), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: loading / writing / done flags, word index, byte count in word.
    logic        m_loading, m_writing, m_done;
    int          m_addr, m_nb, m_cnt, m_sum, m_wr_addr;
    logic [31:0] m_word, m_wr_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading <= 1'b0; m_writing <= 1'b0; m_done <= 1'b0;
            m_addr <= 0; m_nb <= 0; m_cnt <= 0; m_sum <= 0; m_wr_addr <= 0;
            m_word <= '0; m_wr_data <= '0;
        end else if (m_writing) begin
            m_writing <= 1'b0;
            if (m_addr + 1 == m_cnt) begin
                m_done <= 1'b1;
            end else begin
                m_addr <= m_addr + 1;
                m_nb <= 0;
                m_loading <= 1'b1;
            end
        end else if (m_loading) begin
            if (byte_valid) begin
                m_sum <= (m_sum + int'(byte_data)) % 256;
                m_nb <= m_nb + 1;
                if (m_nb == 3) begin
                    m_loading <= 1'b0;
                    m_writing <= 1'b1;
                    m_wr_addr <= m_addr;
                    m_wr_data <= m_word | (32'(byte_data) << 24);
                    m_word <= '0;
                end else begin
                    m_word <= m_word | (32'(byte_data) << (8 * m_nb));
                end
            end
        end else if (start) begin
            m_cnt <= (int'(word_count) > DEPTH) ? DEPTH : int'(word_count);
            m_addr <= 0; m_nb <= 0; m_sum <= 0; m_word <= '0;
            m_done <= (word_count == '0);
            m_loading <= (word_count != '0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("byte_ready", 32'(byte_ready), 32'(m_loading));
            chk("wr_en", 32'(wr_en), 32'(m_writing));
            chk("busy", 32'(busy), 32'(m_loading | m_writing));
            chk("done", 32'(done), 32'(m_done));
            chk("cpu_rst", 32'(cpu_rst), 32'(!m_done));
            chk("checksum", 32'(checksum), 32'(m_sum));
            chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            chk("wr_data", wr_data, m_wr_data);
            if (wr_en) $display("write addr %0d data %h", wr_addr, wr_data);
        end
    end

    logic [31:0] tb_mem [DEPTH];
    always @(posedge clk) if (wr_en) tb_mem[wr_addr] <= wr_data;

    logic [7:0] stim [256];
    logic [7:0] accq [$];

    task automatic do_start(input int wc);
        @(posedge clk); #2;
        start = 1'b1;
        word_count = (AW+1)'(wc);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // mode 0: valid held, 1: valid every other cycle, 2: random valid
    task automatic run_load(input int wc, input int nbytes, input int mode,
                            input int stop_after, input bit pulse_start);
        int idx = 0;
        int cyc = 0;
        bit pv = 0;
        bit pr = 0;
        accq.delete();
        do_start(wc);
        forever begin
            @(posedge clk); #2;
            if (pv && pr) begin
                accq.push_back(stim[idx]);
                idx++;
            end
            if (stop_after >= 0 && idx == stop_after) break;
            if (done) break;
            if (cyc > 3000) begin
                chk("load_timeout", 32'(cyc), 32'(0));
                break;
            end
            cyc++;
            case (mode)
                0:       byte_valid = (idx < nbytes);
                1:       byte_valid = cyc[0] && (idx < nbytes);
                default: byte_valid = ($urandom_range(2) != 0) && (idx < nbytes);
            endcase
            byte_data = stim[idx % 256];
            start = pulse_start && busy && ($urandom_range(3) == 0);
            word_count = (AW+1)'($urandom);
            pv = byte_valid;
            pr = byte_ready;
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_image(input int n);
        logic [31:0] exp;
        chk("accepted_bytes", 32'(accq.size()), 32'(4 * n));
        for (int i = 0; i < n && 4 * i + 3 < accq.size(); i++) begin
            exp = {accq[4*i+3], accq[4*i+2], accq[4*i+1], accq[4*i]};
            chk("mem_image", tb_mem[i], exp);
        end
    endtask

    task automatic set_bytes(input logic [63:0] b, input int n);
        for (int i = 0; i < n; i++) stim[i] = b[8*i +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'(1));
        chk("rst_byte_ready", 32'(byte_ready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", wr_data, 32'(0));
        #1 rst_n = 1'b1;

        // Two-word program, valid held high
        set_bytes(64'h0000_0513_0FF0_0313, 8);
        run_load(2, 8, 0, -1, 0);
        check_image(2);
        chk("t1_word0", tb_mem[0], 32'h0FF0_0313);
        chk("t1_word1", tb_mem[1], 32'h0000_0513);
        chk("t1_checksum", 32'(checksum), 32'h2D);
        chk("t1_cpu_rst", 32'(cpu_rst), 32'(0));

        // Same program, valid toggling
        run_load(2, 8, 1, -1, 0);
        check_image(2);
        chk("t2_word1", tb_mem[1], 32'h0000_0513);
        chk("t2_checksum", 32'(checksum), 32'h2D);

        // Zero-length load
        run_load(0, 0, 0, -1, 0);
        chk("t3_done", 32'(done), 32'(1));
        chk("t3_checksum", 32'(checksum), 32'(0));
        chk("t3_bytes", 32'(accq.size()), 32'(0));

        // Oversized count clamps to the memory depth
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
        run_load(40, 160, 0, -1, 0);
        check_image(DEPTH);
        byte_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            chk("t4_no_extra_ready", 32'(byte_ready), 32'(0));
        end
        byte_valid = 1'b0;

        // Reset mid-load after 2 words and 2 bytes
        run_load(4, 16, 2, 10, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_cpu_rst", 32'(cpu_rst), 32'(1));
        chk("t5_rst_checksum", 32'(checksum), 32'(0));
        chk("t5_rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("t5_rst_byte_ready", 32'(byte_ready), 32'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
        run_load(1, 4, 2, -1, 0);
        check_image(1);

        // Reload from DONE with stray start pulses during the load
        set_bytes(64'h0000_0000_0000_0593, 4);
        run_load(1, 4, 2, -1, 1);
        check_image(1);
        chk("t6_word0", tb_mem[0], 32'h0000_0593);
        chk("t6_checksum", 32'(checksum), 32'h98);

        // Randomized loads
        for (int t = 0; t < 6; t++) begin
            int wc;
            wc = $urandom_range(1, 8);
            for (int i = 0; i < 4 * wc; i++) stim[i] = 8'($urandom);
            run_load(wc, 4 * wc, 2, -1, 1);
            check_image(wc);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
